// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: phase one-hot encodings, default NOP
// and fetch state encodings.
package instruction_fetch_pkg;

  localparam logic [4:0] PH_F = 5'b00001;
  localparam logic [4:0] PH_D = 5'b00010;
  localparam logic [4:0] PH_E = 5'b00100;
  localparam logic [4:0] PH_M = 5'b01000;
  localparam logic [4:0] PH_W = 5'b10000;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_BUSY = 1'b1
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_timeout.sv
// 8-bit wait-state counter for an outstanding fetch; expired flags the final
// permitted cycle so the caller can abort on that same edge.
module fetch_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] count,
  output logic       expired
);

  localparam logic [7:0] LAST = (LIMIT == 0) ? 8'd0 : 8'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en)
      count <= count + 8'd1;
  end

  // LIMIT of zero disables the abort entirely.
  assign expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: samples pc in PH_F, runs a req/ack read with instruction memory,
// latches the word into ir and stalls the sequencer while the read is pending.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSN       = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hlt,
  input  logic [4:0]  phase,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        if_stall,
  output logic        fetch_err
);

  if_state_e  state;
  logic       clear;
  logic       tmo_clr;
  logic       tmo_en;
  logic       tmo_expired;
  logic [7:0] tmo_count;

  assign clear   = !n_rst || hlt;
  // Counter idles at zero so the first BUSY cycle always sees count==0.
  assign tmo_clr = clear || (state == IF_IDLE);
  assign tmo_en  = (state == IF_BUSY) && !imem_ack;

  fetch_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .count   (tmo_count),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IF_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir        <= NOP_INSN;
      ir_valid  <= 1'b0;
      if_stall  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IF_IDLE: begin
          if (phase == PH_F) begin
            if (pc[1:0] == 2'b00) begin
              imem_addr <= pc;
              imem_req  <= 1'b1;
              if_stall  <= 1'b1;
              ir_valid  <= 1'b0;
              state     <= IF_BUSY;
            end else begin
              ir        <= NOP_INSN;
              ir_valid  <= 1'b1;
              fetch_err <= 1'b1;
            end
          end
        end
        IF_BUSY: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            if_stall <= 1'b0;
            state    <= IF_IDLE;
          end else if (tmo_expired) begin
            ir        <= NOP_INSN;
            ir_valid  <= 1'b1;
            imem_req  <= 1'b0;
            if_stall  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a 4-cycle timeout.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        hlt = 1'b0;
  logic [4:0]  phase = PH_W;
  logic [31:0] pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic        if_stall;
  logic        fetch_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instruction_fetch #(.TIMEOUT_CYCLES(4), .NOP_INSN(32'h0000_0000)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .hlt        (hlt),
    .phase      (phase),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .if_stall   (if_stall),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after this are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
    phase = PH_F; pc = addr;
    tick();
    phase = PH_D; pc = addr + 32'd4;
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_stall", {31'd0, if_stall}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    n_rst = 1'b1;
    tick();

    // Zero-wait fetch
    phase = PH_F; pc = 32'h40;
    tick();
    check("zw_req", {31'd0, imem_req}, 32'd1);
    check("zw_addr", imem_addr, 32'h40);
    check("zw_stall_t1", {31'd0, if_stall}, 32'd1);
    check("zw_valid_t1", {31'd0, ir_valid}, 32'd0);
    phase = PH_D; pc = 32'h44;
    imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
    tick();
    imem_ack = 1'b0;
    check("zw_ir", ir, 32'h2408_0005);
    check("zw_valid", {31'd0, ir_valid}, 32'd1);
    check("zw_stall_t2", {31'd0, if_stall}, 32'd0);
    check("zw_req_t2", {31'd0, imem_req}, 32'd0);

    // Wait states: ack on the last cycle before timeout would fire
    phase = PH_F; pc = 32'h40;
    tick();
    phase = PH_D; pc = 32'h44; imem_rdata = 32'h1111_2222;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ws_req_t%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("ws_addr_t%0d", i), imem_addr, 32'h40);
      check($sformatf("ws_stall_t%0d", i), {31'd0, if_stall}, 32'd1);
      if (i == 4) imem_ack = 1'b1;
      tick();
    end
    imem_ack = 1'b0;
    check("ws_ir", ir, 32'h1111_2222);
    check("ws_valid", {31'd0, ir_valid}, 32'd1);
    check("ws_stall", {31'd0, if_stall}, 32'd0);
    check("ws_err", {31'd0, fetch_err}, 32'd0);
    phase = PH_E;
    tick();
    check("hold_ir", ir, 32'h1111_2222);

    // Timeout after 4 BUSY cycles
    phase = PH_F; pc = 32'h80;
    tick();
    phase = PH_D;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_req_t%0d", i), {31'd0, imem_req}, 32'd1);
      tick();
    end
    check("to_req", {31'd0, imem_req}, 32'd0);
    check("to_stall", {31'd0, if_stall}, 32'd0);
    check("to_ir", ir, 32'd0);
    check("to_valid", {31'd0, ir_valid}, 32'd1);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
    tick();
    imem_ack = 1'b0;
    check("spur_ir", ir, 32'd0);
    check("spur_req", {31'd0, imem_req}, 32'd0);
    do_fetch(32'h100, 32'h3333_4444);
    check("sticky_ir", ir, 32'h3333_4444);
    check("sticky_err", {31'd0, fetch_err}, 32'd1);

    // Misaligned pc
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("rst2_err", {31'd0, fetch_err}, 32'd0);
    do_fetch(32'h10, 32'habcd_0001);
    check("pre_mis_ir", ir, 32'habcd_0001);
    phase = PH_F; pc = 32'h42;
    tick();
    phase = PH_D;
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_stall", {31'd0, if_stall}, 32'd0);
    check("mis_ir", ir, 32'd0);
    check("mis_valid", {31'd0, ir_valid}, 32'd1);
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    tick();
    check("mis_stall2", {31'd0, if_stall}, 32'd0);

    // Reset mid-fetch, then a clean fetch from pc=0
    do_fetch(32'h20, 32'h7777_8888);
    phase = PH_F; pc = 32'h40;
    tick();
    phase = PH_D;
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("mr_req", {31'd0, imem_req}, 32'd0);
    check("mr_addr", imem_addr, 32'd0);
    check("mr_ir", ir, 32'd0);
    check("mr_valid", {31'd0, ir_valid}, 32'd0);
    check("mr_stall", {31'd0, if_stall}, 32'd0);
    check("mr_err", {31'd0, fetch_err}, 32'd0);
    phase = PH_F; pc = 32'h0;
    tick();
    check("mr2_req", {31'd0, imem_req}, 32'd1);
    check("mr2_stall", {31'd0, if_stall}, 32'd1);
    phase = PH_D; imem_ack = 1'b1; imem_rdata = 32'h0c00_0010;
    tick();
    imem_ack = 1'b0;
    check("mr2_ir", ir, 32'h0c00_0010);
    check("mr2_valid", {31'd0, ir_valid}, 32'd1);

    // hlt in BUSY with ack in the same cycle
    phase = PH_F; pc = 32'h24;
    tick();
    phase = PH_D;
    hlt = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_aaaa;
    tick();
    hlt = 1'b0;
    check("hlt_ir", ir, 32'd0);
    check("hlt_valid", {31'd0, ir_valid}, 32'd0);
    check("hlt_req", {31'd0, imem_req}, 32'd0);
    check("hlt_stall", {31'd0, if_stall}, 32'd0);
    tick();
    imem_ack = 1'b0;
    check("late_ack_ir", ir, 32'd0);
    check("late_ack_valid", {31'd0, ir_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter in the multi-cycle (F/D/E/M/W phase) CPU.
- In PH_F it samples the current pc, which the program counter advances to pc+4 at the end of that same cycle.
- It then runs a req/ack read handshake with instruction memory and latches the returned word into the instruction register (ir).
- While the read is outstanding it stalls the phase sequencer, so decode never consumes a stale ir.

Parameters:
TIMEOUT_CYCLES, 16, cycles in BUSY without ack before the fetch is aborted; 0 disables the timeout; max 255.
NOP_INSN, 32'h0000_0000, value loaded into ir on abort, misalignment or clear.

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  reset; synchronous, active-low
hlt  input  1  halt; synchronous clear, same effect as reset
phase  input  5  one-hot phase from sequencer (`PH_F .. `PH_W)
pc  input  32  current program counter
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word address of the request
imem_ack  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  instruction word
ir  output  32  instruction register
ir_valid  output  1  ir holds the word for the current instruction
if_stall  output  1  sequencer must hold in PH_D while high
fetch_err  output  1  sticky error: misaligned pc or timeout

Behaviour:
- Reset (n_rst low at a clock edge) or hlt high:
  - state <= IDLE.
  - imem_req, ir_valid, if_stall, fetch_err <= 0.
  - imem_addr <= 0; ir <= NOP_INSN; timeout counter <= 0.
  - This applies mid-fetch too: the outstanding request is dropped, and a late ack is ignored.
- States: IDLE, BUSY.
- IDLE, phase==`PH_F, pc[1:0]==0:
  - imem_addr <= pc; imem_req <= 1; if_stall <= 1; ir_valid <= 0; count <= 0; go to BUSY.
- IDLE, phase==`PH_F, pc[1:0]!=0:
  - No request; ir <= NOP_INSN; ir_valid <= 1; fetch_err <= 1; stay IDLE.
- IDLE, any other phase: hold all outputs.
- BUSY:
  - imem_req stays 1 and imem_addr stays stable until imem_ack is sampled high.
  - On imem_ack: ir <= imem_rdata; ir_valid <= 1; imem_req <= 0; if_stall <= 0; go to IDLE.
  - No ack: count <= count+1.
  - When TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1 with no ack: imem_req <= 0; if_stall <= 0; ir <= NOP_INSN; ir_valid <= 1; fetch_err <= 1; go to IDLE.
  - Ack and timeout in the same cycle: ack wins, fetch_err unchanged.
- imem_ack while imem_req==0 is ignored.
- Latency, with the PH_F cycle at t:
  - imem_req and if_stall are high from t+1.
  - Zero-wait ack at t+1 gives ir/ir_valid at t+2, and if_stall is high for exactly one cycle.
  - Each wait state adds one cycle.
- fetch_err is cleared only by reset or hlt.
- Phase sequencer contract: it stays in PH_D while if_stall==1, so PH_F cannot recur during BUSY.
- The address is taken from the pc sampled in the PH_F cycle, not the incremented value.

Decomposition:
- The phase encodings `PH_F/`PH_D/`PH_E/`PH_M/`PH_W and NOP_INSN default belong in the shared header.
- Add state encodings IF_IDLE/IF_BUSY to the shared header.
- Optional sub-module fetch_timeout: 8-bit counter with clear, enable and an expired flag. Otherwise a single module.

Test Plan:
- Zero-wait fetch: pc=0x40 in PH_F, imem_rdata=0x2408_0005 with ack at t+1 -> imem_addr=0x40; if_stall high only at t+1; ir=0x2408_0005 with ir_valid=1 at t+2.
- Wait states: ack at t+4 -> imem_req and imem_addr=0x40 stable t+1..t+4; if_stall high t+1..t+4; ir valid at t+5.
- Timeout: TIMEOUT_CYCLES=4, no ack -> imem_req drops after 4 BUSY cycles; ir=0; fetch_err=1; a later spurious ack leaves ir unchanged.
- Misaligned: pc=0x42 in PH_F -> imem_req stays 0; ir=NOP; fetch_err=1 next cycle; if_stall never asserted.
- Reset mid-fetch: n_rst low at t+2 while BUSY -> all outputs at reset values next edge; next PH_F with pc=0 starts a clean fetch.
- hlt in BUSY with ack the same cycle -> hlt wins: ir=NOP, ir_valid=0, imem_req=0.
